// File: rtl/sf_serializer.sv
// rtl/sf_serializer.sv - MP3 Layer III part-2 scalefactor bit serializer
//
// Purpose: latches one granule/channel's side info and scalefactors on
// start, then emits the scalefactor bits MSB first over a valid/ready
// serial stream. The bit widths come from scalefac_compress (slen1/slen2).
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   start                   one-cycle request; inputs latched in IDLE
//   gr, scalefac_compress,
//   window_switching_flag,
//   block_type,
//   mixed_block_flag, scfsi side-info fields selecting layout and widths
//   scalefac_l [21][4]      long-block scalefactors, index = sfb
//   scalefac_s [12][3][4]   short-block scalefactors, [sfb][window]
//   axiready                downstream accepts the current bit
//   axiod / axiov           serial data bit / valid
//   busy, done              transfer in progress / end-of-transfer pulse
//   part2_length            number of bits emitted in the last transfer
module sf_serializer (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   gr,
  input  logic [3:0]             scalefac_compress,
  input  logic                   window_switching_flag,
  input  logic [1:0]             block_type,
  input  logic                   mixed_block_flag,
  input  logic [3:0]             scfsi,
  input  logic [20:0][3:0]       scalefac_l,
  input  logic [11:0][2:0][3:0]  scalefac_s,
  input  logic                   axiready,
  output logic                   axiod,
  output logic                   axiov,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             part2_length
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  localparam logic [1:0] M_LONG  = 2'd0;
  localparam logic [1:0] M_SHORT = 2'd1;
  localparam logic [1:0] M_MIXED = 2'd2;

  state_t                  state_q, state_d;
  logic                    gr_q, gr_d;
  logic [1:0]              mode_q, mode_d;
  logic [3:0]              scfsi_q, scfsi_d;
  logic [2:0]              slen1_q, slen1_d, slen2_q, slen2_d;
  logic [20:0][3:0]        sl_q, sl_d;
  logic [11:0][2:0][3:0]   ss_q, ss_d;
  logic [5:0]              elem_q, elem_d;
  logic [1:0]              bit_q, bit_d;
  logic [6:0]              cnt_q, cnt_d;
  logic [7:0]              p2_q, p2_d;

  logic [2:0]              tab_slen1, tab_slen2;
  logic [3:0]              cur_val;
  logic [2:0]              cur_slen;
  logic                    cur_skip, cur_last, cur_emit;
  logic [5:0]              q3, r3, kidx;
  logic [1:0]              grp;
  logic [2:0]              sel;
  logic                    adv;

  // slen1/slen2 width tables indexed by scalefac_compress
  always_comb begin
    tab_slen1 = 3'd0;
    tab_slen2 = 3'd0;
    case (scalefac_compress)
      4'd0:  begin tab_slen1 = 3'd0; tab_slen2 = 3'd0; end
      4'd1:  begin tab_slen1 = 3'd0; tab_slen2 = 3'd1; end
      4'd2:  begin tab_slen1 = 3'd0; tab_slen2 = 3'd2; end
      4'd3:  begin tab_slen1 = 3'd0; tab_slen2 = 3'd3; end
      4'd4:  begin tab_slen1 = 3'd3; tab_slen2 = 3'd0; end
      4'd5:  begin tab_slen1 = 3'd1; tab_slen2 = 3'd1; end
      4'd6:  begin tab_slen1 = 3'd1; tab_slen2 = 3'd2; end
      4'd7:  begin tab_slen1 = 3'd1; tab_slen2 = 3'd3; end
      4'd8:  begin tab_slen1 = 3'd2; tab_slen2 = 3'd1; end
      4'd9:  begin tab_slen1 = 3'd2; tab_slen2 = 3'd2; end
      4'd10: begin tab_slen1 = 3'd2; tab_slen2 = 3'd3; end
      4'd11: begin tab_slen1 = 3'd3; tab_slen2 = 3'd1; end
      4'd12: begin tab_slen1 = 3'd3; tab_slen2 = 3'd2; end
      4'd13: begin tab_slen1 = 3'd3; tab_slen2 = 3'd3; end
      4'd14: begin tab_slen1 = 3'd4; tab_slen2 = 3'd2; end
      default: begin tab_slen1 = 3'd4; tab_slen2 = 3'd3; end
    endcase
  end

  // Map the element index onto (value, width, skip) from latched state only,
  // so axiov/axiod never depend on axiready.
  always_comb begin
    cur_val  = 4'd0;
    cur_slen = 3'd0;
    cur_skip = 1'b0;
    cur_last = 1'b0;
    q3       = 6'd0;
    r3       = 6'd0;
    kidx     = 6'd0;
    grp      = 2'd0;
    case (mode_q)
      M_SHORT: begin
        q3       = elem_q / 6'd3;
        r3       = elem_q % 6'd3;
        cur_val  = ss_q[q3[3:0]][r3[1:0]];
        cur_slen = (q3 < 6'd6) ? slen1_q : slen2_q;
        cur_last = (elem_q == 6'd35);
      end
      M_MIXED: begin
        if (elem_q < 6'd8) begin
          cur_val  = sl_q[elem_q[4:0]];
          cur_slen = slen1_q;
        end else begin
          // elements 8.. map to short sfb 3.. : (e-8)+9 = e+1, so sfb=(e+1)/3
          kidx     = elem_q + 6'd1;
          q3       = kidx / 6'd3;
          r3       = kidx % 6'd3;
          cur_val  = ss_q[q3[3:0]][r3[1:0]];
          cur_slen = (q3 < 6'd6) ? slen1_q : slen2_q;
        end
        cur_last = (elem_q == 6'd34);
      end
      default: begin
        if (elem_q < 6'd6)       grp = 2'd0;
        else if (elem_q < 6'd11) grp = 2'd1;
        else if (elem_q < 6'd16) grp = 2'd2;
        else                     grp = 2'd3;
        cur_val  = sl_q[elem_q[4:0]];
        cur_slen = grp[1] ? slen2_q : slen1_q;
        cur_skip = gr_q & scfsi_q[grp];
        cur_last = (elem_q == 6'd20);
      end
    endcase
  end

  assign cur_emit = (cur_slen != 3'd0) && !cur_skip;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gr_q    <= 1'b0;
      mode_q  <= M_LONG;
      scfsi_q <= 4'd0;
      slen1_q <= 3'd0;
      slen2_q <= 3'd0;
      sl_q    <= '0;
      ss_q    <= '0;
      elem_q  <= 6'd0;
      bit_q   <= 2'd0;
      cnt_q   <= 7'd0;
      p2_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      gr_q    <= gr_d;
      mode_q  <= mode_d;
      scfsi_q <= scfsi_d;
      slen1_q <= slen1_d;
      slen2_q <= slen2_d;
      sl_q    <= sl_d;
      ss_q    <= ss_d;
      elem_q  <= elem_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      p2_q    <= p2_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    gr_d    = gr_q;
    mode_d  = mode_q;
    scfsi_d = scfsi_q;
    slen1_d = slen1_q;
    slen2_d = slen2_q;
    sl_d    = sl_q;
    ss_d    = ss_q;
    elem_d  = elem_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    p2_d    = p2_q;
    adv     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SEND;
          gr_d    = gr;
          scfsi_d = scfsi;
          slen1_d = tab_slen1;
          slen2_d = tab_slen2;
          sl_d    = scalefac_l;
          ss_d    = scalefac_s;
          if (window_switching_flag && block_type == 2'd2)
            mode_d = mixed_block_flag ? M_MIXED : M_SHORT;
          else
            mode_d = M_LONG;
          elem_d  = 6'd0;
          bit_d   = 2'd0;
          cnt_d   = 7'd0;
        end
      end
      S_SEND: begin
        if (!cur_emit) begin
          adv = 1'b1;
        end else if (axiready) begin
          cnt_d = cnt_q + 7'd1;
          if ({1'b0, bit_q} == cur_slen - 3'd1) begin
            bit_d = 2'd0;
            adv   = 1'b1;
          end else begin
            bit_d = bit_q + 2'd1;
          end
        end
        if (adv) begin
          if (cur_last) begin
            state_d = S_DONE;
            p2_d    = {1'b0, cnt_d};
          end else begin
            elem_d = elem_q + 6'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    sel          = cur_slen - 3'd1 - {1'b0, bit_q};
    axiov        = (state_q == S_SEND) && cur_emit;
    axiod        = axiov & cur_val[sel[1:0]];
    busy         = (state_q != S_IDLE);
    done         = (state_q == S_DONE);
    part2_length = p2_q;
  end

endmodule

// File: tb/tb_sf_serializer.sv
// tb/tb_sf_serializer.sv - scoreboard bench for sf_serializer
module tb_sf_serializer;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic                  gr;
  logic [3:0]            scalefac_compress;
  logic                  window_switching_flag;
  logic [1:0]            block_type;
  logic                  mixed_block_flag;
  logic [3:0]            scfsi;
  logic [20:0][3:0]      scalefac_l;
  logic [11:0][2:0][3:0] scalefac_s;
  logic                  axiready;
  logic                  axiod;
  logic                  axiov;
  logic                  busy;
  logic                  done;
  logic [7:0]            part2_length;

  int   n_chk = 0;
  int   n_err = 0;
  logic exp_q[$];
  logic got_q[$];
  logic ref_q[$];

  int slen1_t[16] = '{0,0,0,0,3,1,1,1,2,2,2,3,3,3,4,4};
  int slen2_t[16] = '{0,1,2,3,0,1,2,3,1,2,3,1,2,3,2,3};
  int grp_lo[4]   = '{0,6,11,16};
  int grp_hi[4]   = '{5,10,15,20};

  sf_serializer dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .start                 (start),
    .gr                    (gr),
    .scalefac_compress     (scalefac_compress),
    .window_switching_flag (window_switching_flag),
    .block_type            (block_type),
    .mixed_block_flag      (mixed_block_flag),
    .scfsi                 (scfsi),
    .scalefac_l            (scalefac_l),
    .scalefac_s            (scalefac_s),
    .axiready              (axiready),
    .axiod                 (axiod),
    .axiov                 (axiov),
    .busy                  (busy),
    .done                  (done),
    .part2_length          (part2_length)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_elem(input logic [3:0] v, input int w);
    for (int b = w - 1; b >= 0; b--) exp_q.push_back(v[b]);
  endtask

  // Reference bitstream built by walking the layout tables directly
  task automatic build_exp();
    int s1, s2;
    s1 = slen1_t[scalefac_compress];
    s2 = slen2_t[scalefac_compress];
    exp_q.delete();
    if (window_switching_flag && block_type == 2'd2 && !mixed_block_flag) begin
      for (int sfb = 0; sfb < 12; sfb++)
        for (int w = 0; w < 3; w++)
          push_elem(scalefac_s[sfb][w], (sfb < 6) ? s1 : s2);
    end else if (window_switching_flag && block_type == 2'd2) begin
      for (int sfb = 0; sfb < 8; sfb++) push_elem(scalefac_l[sfb], s1);
      for (int sfb = 3; sfb < 12; sfb++)
        for (int w = 0; w < 3; w++)
          push_elem(scalefac_s[sfb][w], (sfb < 6) ? s1 : s2);
    end else begin
      for (int g = 0; g < 4; g++)
        if (!(gr && scfsi[g]))
          for (int sfb = grp_lo[g]; sfb <= grp_hi[g]; sfb++)
            push_elem(scalefac_l[sfb], (g < 2) ? s1 : s2);
    end
  endtask

  // ready_mode 0: always ready; 1: toggles 1,0,1,0
  task automatic run(input int ready_mode, input int exp_p2, input int exp_idle,
                     input int exp_cyc, input bit poke_start);
    int   cyc, idle, nacc;
    bit   fin, stalled;
    logic held;
    build_exp();
    got_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; idle = 0; nacc = 0; fin = 1'b0; stalled = 1'b0; held = 1'b0;
    while (!fin && cyc < 2000) begin
      cyc++;
      axiready = (ready_mode == 0) ? 1'b1 : ((cyc % 2) == 1);
      start = poke_start && (cyc == 10);
      if (done) begin
        fin = 1'b1;
        chk("busy_at_done", busy, 1'b1);
        chk("p2_len", part2_length, exp_p2);
      end else if (axiov) begin
        if (stalled) chk("stall_hold", axiod, held);
        if (axiready) begin
          nacc++;
          got_q.push_back(axiod);
          if (exp_q.size() == 0) chk("extra_bit", 1, 0);
          else chk("bit", axiod, exp_q.pop_front());
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = axiod;
        end
      end else begin
        idle++;
      end
      if (!fin) @(negedge clk);
    end
    start = 1'b0;
    chk("timeout", fin, 1'b1);
    chk("bits_left", exp_q.size(), 0);
    chk("nbits", nacc, exp_p2);
    if (exp_idle >= 0) chk("idle_cycles", idle, exp_idle);
    if (exp_cyc >= 0) chk("cycles", cyc, exp_cyc);
    @(negedge clk);
    chk("done_pulse", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    axiready = 1'b1;
  endtask

  task automatic set_long(input logic g, input logic [3:0] comp, input logic [3:0] fs);
    gr = g;
    scalefac_compress = comp;
    window_switching_flag = 1'b0;
    block_type = 2'd0;
    mixed_block_flag = 1'b0;
    scfsi = fs;
    for (int i = 0; i < 21; i++) scalefac_l[i] = 4'(i);
  endtask

  initial begin
    logic [3:0] tmp;
    bit seen_done;
    rst_n = 1'b0; start = 1'b0; axiready = 1'b1;
    gr = 1'b0; scalefac_compress = 4'd0; window_switching_flag = 1'b0;
    block_type = 2'd0; mixed_block_flag = 1'b0; scfsi = 4'd0;
    scalefac_l = '0; scalefac_s = '0;
    repeat (3) @(negedge clk);
    chk("rst_axiov", axiov, 1'b0);
    chk("rst_axiod", axiod, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_p2", part2_length, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Long, compress=15, gr=0; a start pulse mid-stream must be ignored
    set_long(1'b0, 4'd15, 4'd0);
    run(0, 74, 0, 75, 1'b1);
    ref_q = got_q;

    // Long, gr=1, groups 0 and 2 reused
    set_long(1'b1, 4'd15, 4'b0101);
    run(0, 35, 11, 47, 1'b0);

    // Short, compress=4 (slen2=0 gives 18 skip cycles)
    gr = 1'b0; scalefac_compress = 4'd4; window_switching_flag = 1'b1;
    block_type = 2'd2; mixed_block_flag = 1'b0; scfsi = 4'd0;
    for (int s = 0; s < 12; s++)
      for (int w = 0; w < 3; w++) scalefac_s[s][w] = 4'(s + w);
    run(0, 54, 18, 73, 1'b0);

    // Mixed, compress=14, random values
    scalefac_compress = 4'd14; mixed_block_flag = 1'b1;
    for (int i = 0; i < 21; i++) scalefac_l[i] = 4'($urandom_range(0, 15));
    for (int s = 0; s < 12; s++)
      for (int w = 0; w < 3; w++) scalefac_s[s][w] = 4'($urandom_range(0, 15));
    run(0, 104, 0, 105, 1'b0);
    if (got_q.size() == 104) begin
      tmp = scalefac_s[3][0];
      for (int b = 0; b < 4; b++) chk("mixed_s30", got_q[32 + b], tmp[3 - b]);
      tmp = scalefac_s[11][2];
      chk("mixed_last1", got_q[102], tmp[1]);
      chk("mixed_last0", got_q[103], tmp[0]);
    end else begin
      chk("mixed_size", got_q.size(), 104);
    end

    // Reset mid-transfer (part2_length is nonzero going in)
    set_long(1'b0, 4'd15, 4'd0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) seen_done = 1'b1;
      @(negedge clk);
    end
    chk("mid_axiov", axiov, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_axiov", axiov, 1'b0);
    chk("mrst_axiod", axiod, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_done", done, 1'b0);
    chk("mrst_p2", part2_length, 8'd0);
    chk("mrst_nodone", seen_done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", done, 1'b0);
    run(0, 74, 0, 75, 1'b0);

    // Backpressure: same stream as the first run, axiod held while stalled
    run(1, 74, -1, -1, 1'b0);
    chk("bp_size", got_q.size(), ref_q.size());
    if (got_q.size() == ref_q.size())
      for (int i = 0; i < ref_q.size(); i++) chk("bp_bit", got_q[i], ref_q[i]);

    // compress=0: every element zero-width
    set_long(1'b0, 4'd0, 4'd0);
    run(0, 0, 21, 22, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sf_serializer.md
# sf_serializer

Scalefactor bitstream packer for the MP3 Layer III path: the transmit-side counterpart of the scalefactor parser. It takes one granule/channel's side-info fields and scalefactor arrays and emits the part-2 scalefactor bits serially, MSB first, using the standard slen1/slen2 widths from `scalefac_compress`. It is used to build encoder output and to generate bit-exact stimulus for the parser in loopback benches.

## Interface
- No parameters.
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous reset, active-low.
- `start`  in  1  one-cycle request to serialize; all inputs below are latched on this cycle.
- `gr`  in  1  granule index (0/1).
- `scalefac_compress`  in  4  selects slen1/slen2.
- `window_switching_flag`  in  1.
- `block_type`  in  2.
- `mixed_block_flag`  in  1.
- `scfsi`  in  4  per-group reuse flags, bit g = group g.
- `scalefac_l`  in  21×4  long-block scalefactors, index = sfb.
- `scalefac_s`  in  12×3×4  short-block scalefactors, [sfb][window].
- `axiready`  in  1  downstream accepts the current bit.
- `axiod`  out  1  serial data bit.
- `axiov`  out  1  `axiod` valid.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse at end of transfer.
- `part2_length`  out  8  bits emitted in the last transfer.

## Operation
- Width tables by `scalefac_compress` 0..15: slen1 = 0,0,0,0,3,1,1,1,2,2,2,3,3,3,4,4; slen2 = 0,1,2,3,0,1,2,3,1,2,3,1,2,3,2,3.
- Each element emits its low slen bits, MSB first. Upper bits are ignored.
- Short mode (wsf=1, block_type=2, mixed=0): 36 elements. sfb 0..5 × win 0..2 use slen1. sfb 6..11 × win 0..2 use slen2. Order is sfb-major, window-minor.
- Mixed mode (wsf=1, block_type=2, mixed=1): 35 elements. Long sfb 0..7 use slen1. Then short sfb 3..5 × win 0..2 use slen1. Then short sfb 6..11 × win 0..2 use slen2.
- Long mode (all other cases): 21 elements in four groups.
  - Group 0: sfb 0..5, slen1.
  - Group 1: sfb 6..10, slen1.
  - Group 2: sfb 11..15, slen2.
  - Group 3: sfb 16..20, slen2.
  - When gr=1 and scfsi[g]=1, every element of group g is skipped.
- Skipped elements and zero-width elements emit no bits.
- States:
  - IDLE: `start` → SEND, latches the inputs, element index and bit index = 0, bit count = 0.
  - SEND: walks the element list.
  - DONE: one cycle, `done`=1, `part2_length` updated, → IDLE.
- `start` outside IDLE is ignored.
- Bit count saturates never; the maximum is 126 bits.

## Timing
- Reset values: `axiov`=0, `axiod`=0, `busy`=0, `done`=0, `part2_length`=0, state IDLE. Reset mid-transfer aborts immediately with no `done`.
- `start` sampled in cycle 0 → SEND from cycle 1. `busy`=1 from cycle 1 through the DONE cycle inclusive.
- In SEND, each cycle handles the current element in one of two ways:
  - Skipped or zero-width element: the cycle has `axiov`=0 and the element index advances.
  - Otherwise: `axiov`=1, `axiod` = value[slen-1-bit_idx].
- A bit transfers on a cycle with `axiov`&&`axiready`. The bit index then advances; after the last bit it resets and the element index advances.
- With `axiov`=1 and `axiready`=0, `axiod` and the indices hold.
- `axiov`/`axiod` are decoded from registers only; there is no combinational path from `axiready`.
- The cycle after the last element is consumed or skipped, the block is in DONE. It returns to IDLE one cycle later, and a new `start` is accepted in that IDLE cycle.
- With `axiready` held at 1 and no skipped elements, a transfer takes 1 + N_elements + N_bits − (elements with slen>0) + 1 cycles. In words: one cycle per bit, one per skipped element, plus the DONE cycle.

## Test plan
- Long, compress=15 (4/3), gr=0, scalefac_l[i]=i; `axiready`=1.
  - Expect 74 bits: 0000,0001,…,1010, then the 3-bit values (i&7) for sfb 11..20.
  - Expect `part2_length`=74 and one `done` pulse.
- Long, gr=1, scfsi=4'b0101, compress=15.
  - Groups 0 and 2 emit nothing; only sfb 6..10 (4b) and 16..20 (3b) are sent.
  - Expect 35 bits and `part2_length`=35.
- Short, compress=4 (3/0), scalefac_s[sfb][w]=sfb+w.
  - Expect 54 bits, then 18 idle skip cycles with `axiov`=0, then `done`.
  - Expect `part2_length`=54.
- Mixed, compress=14 (4/2).
  - Expect 104 bits. Bits 32..35 equal scalefac_s[3][0], and the last 2 bits equal scalefac_s[11][2]&3.
- Backpressure: rerun the first scenario with `axiready` toggling 1,0,1,0.
  - Accepted bit sequence must match the unstalled run exactly. `axiod` must stay stable during stalls, and the total takes 74 accepted bits.
- compress=0: 21 skip cycles, `done`, `part2_length`=0.
- Reset mid-transfer: assert `rst_n`=0 mid-stream.
  - All outputs go to 0 the next cycle with no `done`.
  - A following `start` runs a clean transfer.
